// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch front end: default widths,
//   the reset fetch address and the buffered fetch entry layout at the default
//   widths. The top level builds a width-matched copy of the entry from its own
//   parameters.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam int          INST_LEN_DEF = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

    // One decoded-side entry: where it came from, what was there, and whether
    // the address was legal for a 32-bit instruction fetch.
    typedef struct packed {
        logic [XLEN_DEF-1:0]     pc;
        logic [INST_LEN_DEF-1:0] inst;
        logic                    misaligned;
    } fetch_entry_t;

    // A fetch address is misaligned when its two low bits are not zero.
    function automatic logic is_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO of DEPTH entries of type T with a flush input.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports
//   clk        in   clock
//   rst        in   synchronous reset, active-high (empties the FIFO)
//   flush      in   synchronous clear, same effect as rst
//   push       in   write push_data at the tail
//   push_data  in   entry to write
//   pop        in   advance the head (ignored while empty)
//   pop_data   out  head entry (valid while !empty)
//   full       out  DEPTH entries held
//   empty      out  no entries held
//   count      out  number of entries held
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  T                   push_data,
    input  logic               pop,
    output T                   pop_data,
    output logic               full,
    output logic               empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a
    // push alongside a pop and the count is preserved.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // decide which slots hold live data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_prefetch.sv
// -----------------------------------------------------------------------------
// fetch_prefetch
//   Instruction-fetch front end. Issues sequential fetch requests, receives
//   in-order responses, buffers {pc, inst, misaligned} in a FIFO and hands the
//   head entry to decode. A redirect reloads the PC, flushes the buffer and
//   counts the responses still in flight so they are discarded on arrival.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc   load a new fetch PC and flush
//   imem_req_valid/ready/addr     request channel to instruction memory
//   imem_resp_valid/data          in-order response, aligned XLEN-bit word
//   if_valid/ready                handshake to decode
//   if_pc, if_inst, if_misaligned head entry presented to decode
// -----------------------------------------------------------------------------
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int             XLEN       = XLEN_DEF,
    parameter int             INST_LEN   = INST_LEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF[XLEN-1:0],
    parameter int             FIFO_DEPTH = 4,
    parameter int             MAX_OUTST  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [XLEN-1:0]     imem_resp_data,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [XLEN-1:0]     if_pc,
    output logic [INST_LEN-1:0] if_inst,
    output logic                if_misaligned
);

    localparam int             CW      = $clog2(MAX_OUTST + 1);
    localparam int             NW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [INST_LEN-1:0] inst;
        logic                misaligned;
    } entry_t;

    logic [XLEN-1:0]     fetch_pc;
    logic [XLEN-1:0]     resp_pc;
    logic [CW-1:0]       outst;
    logic [CW-1:0]       drop_cnt;
    logic [CW-1:0]       resp_dec;
    logic [INST_LEN-1:0] sel_inst;
    entry_t              push_entry;
    entry_t              head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [NW-1:0]       fifo_count;
    logic                credit_ok;
    logic                req_fire;
    logic                resp_drop;
    logic                push;

    // Counting in-flight requests against free FIFO slots means every
    // response always has somewhere to land.
    assign credit_ok      = (int'(outst) + int'(fifo_count)) < FIFO_DEPTH;
    assign imem_req_valid = !rst && !redirect_valid && (int'(outst) < MAX_OUTST) && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop = (drop_cnt != '0);
    assign resp_dec  = CW'(imem_resp_valid);
    assign push      = imem_resp_valid && !resp_drop && !redirect_valid && !rst;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_inst = imem_resp_data[INST_LEN-1:0];
        // A 64-bit word holds two instructions; pc[2] picks the upper one.
        if (XLEN == 64 && resp_pc[2]) sel_inst = imem_resp_data[XLEN-1 -: INST_LEN];
    end

    assign push_entry = '{pc: resp_pc, inst: sel_inst, misaligned: is_misaligned(resp_pc[1:0])};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outst    <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old
            // stream; a response arriving right now is discarded by the flush.
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            outst    <= outst - resp_dec;
            drop_cnt <= outst - resp_dec;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
            if (imem_resp_valid) begin
                if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
                else           resp_pc  <= resp_pc + PC_STEP;
            end
            outst <= outst + CW'(req_fire) - resp_dec;
        end
    end

    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (if_valid && if_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign if_valid      = !fifo_empty && !rst;
    assign if_pc         = head.pc;
    assign if_inst       = head.inst;
    assign if_misaligned = head.misaligned;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst) push |-> !fifo_full);
    a_resp_owed   : assert property (@(posedge clk) disable iff (rst) imem_resp_valid |-> (outst != '0));
    a_drop_bound  : assert property (@(posedge clk) disable iff (rst) drop_cnt <= outst);

endmodule
